// File: rtl/alu_mult_issue_sched_pkg.sv
// Shared constants for the ALU/MULT issue scheduler and the MULT unit.
// Keep MULT_LAT_DEFAULT in step with the MULT pipeline depth so that CDB reservations line up.
package alu_mult_issue_sched_pkg;

    localparam logic [1:0] CDB_SEL_NONE = 2'b00;
    localparam logic [1:0] CDB_SEL_ALU  = 2'b01;
    localparam logic [1:0] CDB_SEL_MULT = 2'b10;

    localparam int NUM_OC_DEFAULT   = 4;
    localparam int MULT_LAT_DEFAULT = 4;

endpackage

// File: rtl/alu_mult_issue_sched_rr_arbiter.sv
// Round-robin pick of the first set req bit at or after ptr, wrapping; combinational.
// Latency 0; no backpressure, the caller gates req and owns the pointer register.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        // Upper segment [ptr..N-1] first, then wrap to the lower segment.
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any     = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                any     = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_mult_issue_sched.sv
// Issue scheduler: one round-robin grant per cycle to the ALU or MULT, with CDB slot reservation for MULT results.
// Grant is same-cycle; ALU ops stall while next cycle's CDB slot belongs to MULT, and while Hold_Sched is high.
module alu_mult_issue_sched
    import alu_mult_issue_sched_pkg::*;
#(
    parameter int NUM_OC   = NUM_OC_DEFAULT,
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int SW       = (NUM_OC > 1) ? $clog2(NUM_OC) : 1,
    parameter int CW       = $clog2(MULT_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_OC-1:0] Req_OC_Sched,
    input  logic [NUM_OC-1:0] IsMult_OC_Sched,
    input  logic              Hold_Sched,
    output logic [NUM_OC-1:0] Grant_Sched_OC,
    output logic [SW-1:0]     Sel_Sched_OC,
    output logic              Valid_Sched_ALU,
    output logic              Valid_Sched_MULT,
    output logic [1:0]        CDB_Sel_Sched,
    output logic [CW-1:0]     MultInFlight_Sched
);

    logic [MULT_LAT-1:1] rsv_q, rsv_d;
    logic [SW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]          cdb_sel_q, cdb_sel_d;
    logic [CW-1:0]       inflight_q, inflight_d;

    logic [NUM_OC-1:0]   elig;
    logic [NUM_OC-1:0]   gnt;
    logic [SW-1:0]       gnt_idx;
    logic                gnt_any;
    logic                valid_alu;
    logic                valid_mult;

    // rst gates eligibility so that grants drop the instant reset asserts.
    always_comb begin
        elig = '0;
        if (!rst && !Hold_Sched) begin
            elig = Req_OC_Sched & (IsMult_OC_Sched | {NUM_OC{~rsv_q[1]}});
        end
    end

    rr_arbiter #(
        .N  (NUM_OC),
        .IW (SW)
    ) u_rr_arbiter (
        .req     (elig),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    always_comb begin
        valid_alu  = |(gnt & ~IsMult_OC_Sched);
        valid_mult = |(gnt & IsMult_OC_Sched);

        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == SW'(NUM_OC - 1)) ? '0 : gnt_idx + SW'(1);
        end

        // Slot 1 is next cycle; a new MULT claims the slot MULT_LAT-1 ahead of next cycle.
        rsv_d = '0;
        for (int k = 1; k < MULT_LAT - 1; k++) begin
            rsv_d[k] = rsv_q[k+1];
        end
        rsv_d[MULT_LAT-1] = valid_mult;

        if (rsv_q[1]) begin
            cdb_sel_d = CDB_SEL_MULT;
        end else if (valid_alu) begin
            cdb_sel_d = CDB_SEL_ALU;
        end else begin
            cdb_sel_d = CDB_SEL_NONE;
        end

        inflight_d = inflight_q + {{(CW-1){1'b0}}, valid_mult} - {{(CW-1){1'b0}}, rsv_q[1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsv_q      <= '0;
            rr_ptr_q   <= '0;
            cdb_sel_q  <= CDB_SEL_NONE;
            inflight_q <= '0;
        end else begin
            rsv_q      <= rsv_d;
            rr_ptr_q   <= rr_ptr_d;
            cdb_sel_q  <= cdb_sel_d;
            inflight_q <= inflight_d;
        end
    end

    assign Grant_Sched_OC     = gnt;
    assign Sel_Sched_OC       = gnt_idx;
    assign Valid_Sched_ALU    = valid_alu;
    assign Valid_Sched_MULT   = valid_mult;
    assign CDB_Sel_Sched      = cdb_sel_q;
    assign MultInFlight_Sched = inflight_q;

endmodule

// File: tb/tb_alu_mult_issue_sched.sv
// Directed bench for alu_mult_issue_sched with NUM_OC=4, MULT_LAT=4.
module tb_alu_mult_issue_sched;

    logic       clk;
    logic       rst;
    logic [3:0] Req_OC_Sched;
    logic [3:0] IsMult_OC_Sched;
    logic       Hold_Sched;
    logic [3:0] Grant_Sched_OC;
    logic [1:0] Sel_Sched_OC;
    logic       Valid_Sched_ALU;
    logic       Valid_Sched_MULT;
    logic [1:0] CDB_Sel_Sched;
    logic [2:0] MultInFlight_Sched;

    int errors = 0;
    int checks = 0;
    bit excl_on = 1'b0;

    alu_mult_issue_sched #(
        .NUM_OC   (4),
        .MULT_LAT (4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .Req_OC_Sched       (Req_OC_Sched),
        .IsMult_OC_Sched    (IsMult_OC_Sched),
        .Hold_Sched         (Hold_Sched),
        .Grant_Sched_OC     (Grant_Sched_OC),
        .Sel_Sched_OC       (Sel_Sched_OC),
        .Valid_Sched_ALU    (Valid_Sched_ALU),
        .Valid_Sched_MULT   (Valid_Sched_MULT),
        .CDB_Sel_Sched      (CDB_Sel_Sched),
        .MultInFlight_Sched (MultInFlight_Sched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; drive() leaves us 4 units after it.
    task automatic drive(input logic [3:0] r, input logic [3:0] m, input logic h);
        Req_OC_Sched    = r;
        IsMult_OC_Sched = m;
        Hold_Sched      = h;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // An ALU issue must never coincide with a MULT-owned next slot.
    always @(negedge clk) begin
        if (excl_on && !rst) begin
            chk("cdb_excl", {31'b0, Valid_Sched_ALU & dut.rsv_q[1]}, 32'd0);
        end
    end

    logic [2:0] exp_inf [5];
    logic [3:0] exp_b2b [5];

    initial begin
        exp_inf = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3};
        exp_b2b = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        rst = 1'b1;
        Req_OC_Sched = 4'b0000;
        IsMult_OC_Sched = 4'b0000;
        Hold_Sched = 1'b0;
        #2;
        Req_OC_Sched = 4'b1111;
        #1;
        chk("rst_grant", Grant_Sched_OC, 4'b0000);
        chk("rst_valid", {Valid_Sched_ALU, Valid_Sched_MULT}, 2'b00);
        chk("rst_cdb", CDB_Sel_Sched, 2'b00);
        chk("rst_inflight", MultInFlight_Sched, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        Req_OC_Sched = 4'b0000;
        excl_on = 1'b1;
        tick();

        // Round-robin fairness over four ALU requesters
        for (int i = 0; i < 4; i++) begin
            drive(4'b1111, 4'b0000, 1'b0);
            chk("rr_grant", Grant_Sched_OC, 4'b0001 << i);
            chk("rr_sel", Sel_Sched_OC, i);
            chk("rr_valid_alu", Valid_Sched_ALU, 1'b1);
            chk("rr_valid_mult", Valid_Sched_MULT, 1'b0);
            chk("rr_cdb", CDB_Sel_Sched, (i == 0) ? 2'b00 : 2'b01);
            tick();
        end
        drive(4'b0000, 4'b0000, 1'b0);
        chk("rr_cdb_last", CDB_Sel_Sched, 2'b01);
        chk("idle_grant", Grant_Sched_OC, 4'b0000);
        tick();

        // MULT/ALU collision: MULT at cycle 0 owns the CDB at cycle 4
        drive(4'b0001, 4'b0001, 1'b0);
        chk("col_grant0", Grant_Sched_OC, 4'b0001);
        chk("col_vmult0", Valid_Sched_MULT, 1'b1);
        tick();
        drive(4'b0000, 4'b0000, 1'b0);
        chk("col_inflight1", MultInFlight_Sched, 3'd1);
        tick();
        drive(4'b0000, 4'b0000, 1'b0);
        tick();
        drive(4'b0010, 4'b0000, 1'b0);
        chk("col_grant3", Grant_Sched_OC, 4'b0000);
        chk("col_valu3", Valid_Sched_ALU, 1'b0);
        tick();
        drive(4'b0010, 4'b0000, 1'b0);
        chk("col_cdb4", CDB_Sel_Sched, 2'b10);
        chk("col_grant4", Grant_Sched_OC, 4'b0010);
        chk("col_valu4", Valid_Sched_ALU, 1'b1);
        chk("col_inflight4", MultInFlight_Sched, 3'd0);
        tick();
        drive(4'b0000, 4'b0000, 1'b0);
        chk("col_cdb5", CDB_Sel_Sched, 2'b01);
        tick();

        // Mixed contention: steer rr_ptr to 0 via entry 3 MULT, whose slot reaches rsv[1] two cycles later
        drive(4'b1000, 4'b1000, 1'b0);
        chk("mix_setup_grant", Grant_Sched_OC, 4'b1000);
        tick();
        drive(4'b0000, 4'b0000, 1'b0);
        tick();
        drive(4'b0000, 4'b0000, 1'b0);
        tick();
        drive(4'b0011, 4'b0010, 1'b0);
        chk("mix_grant", Grant_Sched_OC, 4'b0010);
        chk("mix_sel", Sel_Sched_OC, 2'd1);
        chk("mix_vmult", Valid_Sched_MULT, 1'b1);
        chk("mix_valu", Valid_Sched_ALU, 1'b0);
        tick();
        chk("mix_cdb", CDB_Sel_Sched, 2'b10);
        chk("mix_inflight", MultInFlight_Sched, 3'd1);
        drive(4'b1111, 4'b0000, 1'b0);
        chk("mix_ptr2_grant", Grant_Sched_OC, 4'b0100);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(4'b0000, 4'b0000, 1'b0);
            tick();
        end
        chk("drain_inflight", MultInFlight_Sched, 3'd0);
        chk("drain_cdb", CDB_Sel_Sched, 2'b00);

        // Back-to-back MULTs from rr_ptr=3
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b1111, 1'b0);
            chk("b2b_grant", Grant_Sched_OC, exp_b2b[i]);
            chk("b2b_vmult", Valid_Sched_MULT, 1'b1);
            tick();
            chk("b2b_inflight", MultInFlight_Sched, exp_inf[i]);
            chk("b2b_cdb", CDB_Sel_Sched, (i >= 3) ? 2'b10 : 2'b00);
        end

        // Asynchronous reset with three MULTs in flight
        Req_OC_Sched = 4'b1111;
        IsMult_OC_Sched = 4'b0000;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_grant", Grant_Sched_OC, 4'b0000);
        chk("arst_valid", {Valid_Sched_ALU, Valid_Sched_MULT}, 2'b00);
        chk("arst_cdb", CDB_Sel_Sched, 2'b00);
        chk("arst_inflight", MultInFlight_Sched, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        drive(4'b0001, 4'b0000, 1'b0);
        chk("post_rst_grant", Grant_Sched_OC, 4'b0001);
        chk("post_rst_valu", Valid_Sched_ALU, 1'b1);
        tick();
        chk("post_rst_cdb", CDB_Sel_Sched, 2'b01);
        chk("post_rst_inflight", MultInFlight_Sched, 3'd0);

        // Hold: rr_ptr is 1 and must survive three held cycles
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 4'b0000, 1'b1);
            chk("hold_grant", Grant_Sched_OC, 4'b0000);
            chk("hold_valid", {Valid_Sched_ALU, Valid_Sched_MULT}, 2'b00);
            tick();
        end
        drive(4'b1111, 4'b0000, 1'b0);
        chk("hold_release_grant", Grant_Sched_OC, 4'b0010);
        chk("hold_release_sel", Sel_Sched_OC, 2'd1);
        tick();
        drive(4'b0000, 4'b0000, 1'b0);
        tick();

        excl_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
